// File: rtl/mult_job_scheduler.sv
// Two-requester multiply job scheduler: round-robin arbitration, fixed six-state
// sequence driving ROM, register file and RAM controls for one product per job.
module mult_job_scheduler (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] adr1_0,
   input  logic [2:0] adr1_1,
   input  logic [2:0] adr2_0,
   input  logic [2:0] adr2_1,
   input  logic [2:0] dst_0,
   input  logic [2:0] dst_1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic [2:0] rom_adr,
   output logic       rf_we,
   output logic       rf_da,
   output logic       rf_sa,
   output logic       rf_sb,
   output logic       ram_we,
   output logic [2:0] ram_adr,
   output logic [2:0] state,
   output logic [7:0] jobs_done
);

   localparam int unsigned AW = 3;
   localparam int unsigned SW = 3;
   localparam int unsigned CW = 8;

   typedef enum logic [SW-1:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      MULT   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } state_t;

   typedef struct packed {
      logic          idx;
      logic [AW-1:0] adr1;
      logic [AW-1:0] adr2;
      logic [AW-1:0] dst;
   } job_t;

   logic [SW-1:0] state_q, state_d;
   job_t          job_q, job_d;
   logic          ptr_q, ptr_d;
   logic          win;
   logic [CW-1:0] cnt_d;

   logic          gnt0_d, gnt1_d, busy_d, done_d, done_id_d;
   logic          rf_we_d, rf_da_d, rf_sa_d, rf_sb_d, ram_we_d;
   logic [AW-1:0] rom_adr_d, ram_adr_d;

   // Next state, job latch, arbitration, and output decode of the upcoming state
   always_comb begin
      state_d   = state_q;
      job_d     = job_q;
      ptr_d     = ptr_q;
      cnt_d     = jobs_done;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      done_id_d = 1'b0;
      rom_adr_d = '0;
      rf_we_d   = 1'b0;
      rf_da_d   = 1'b0;
      rf_sa_d   = 1'b0;
      rf_sb_d   = 1'b0;
      ram_we_d  = 1'b0;
      ram_adr_d = '0;

      // Both requesting: the one not served last wins
      if (req0 && req1) win = ~ptr_q;
      else              win = req1;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d   = LOAD_A;
               ptr_d     = win;
               job_d.idx = win;
               job_d.adr1 = win ? adr1_1 : adr1_0;
               job_d.adr2 = win ? adr2_1 : adr2_0;
               job_d.dst  = win ? dst_1  : dst_0;
            end
         end
         LOAD_A: state_d = LOAD_B;
         LOAD_B: state_d = MULT;
         MULT:   state_d = WRITE;
         WRITE: begin
            state_d = DONE;
            cnt_d   = jobs_done + CW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Controls are registered from the next state so they line up with state
      busy_d = (state_d != IDLE);
      case (state_d)
         LOAD_A: begin
            gnt0_d    = ~job_d.idx;
            gnt1_d    = job_d.idx;
            rom_adr_d = job_d.adr1;
            rf_we_d   = 1'b1;
         end
         LOAD_B: begin
            rom_adr_d = job_d.adr2;
            rf_we_d   = 1'b1;
            rf_da_d   = 1'b1;
         end
         MULT: begin
            rf_sb_d = 1'b1;
         end
         WRITE: begin
            rf_sb_d   = 1'b1;
            ram_we_d  = 1'b1;
            ram_adr_d = job_d.dst;
         end
         DONE: begin
            done_d    = 1'b1;
            done_id_d = job_d.idx;
            ram_adr_d = job_d.dst;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         job_q     <= '0;
         ptr_q     <= 1'b1;
         jobs_done <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_id   <= 1'b0;
         rom_adr   <= '0;
         rf_we     <= 1'b0;
         rf_da     <= 1'b0;
         rf_sa     <= 1'b0;
         rf_sb     <= 1'b0;
         ram_we    <= 1'b0;
         ram_adr   <= '0;
      end else begin
         state_q   <= state_d;
         job_q     <= job_d;
         ptr_q     <= ptr_d;
         jobs_done <= cnt_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         busy      <= busy_d;
         done      <= done_d;
         done_id   <= done_id_d;
         rom_adr   <= rom_adr_d;
         rf_we     <= rf_we_d;
         rf_da     <= rf_da_d;
         rf_sa     <= rf_sa_d;
         rf_sb     <= rf_sb_d;
         ram_we    <= ram_we_d;
         ram_adr   <= ram_adr_d;
      end
   end

   assign state = state_q;

endmodule

// File: doc/mult_job_scheduler.md
MULT_JOB_SCHEDULER -- requirements
Module: mult_job_scheduler

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 The block SHALL expose the following ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-low reset
- req0 / req1  input  1 each  job request from requester 0 / 1; held high until granted
- adr1_0 / adr1_1  input  3 each  ROM address of multiplicand 1, requester 0 / 1
- adr2_0 / adr2_1  input  3 each  ROM address of multiplicand 2, requester 0 / 1
- dst_0 / dst_1  input  3 each  RAM address for the product, requester 0 / 1
- gnt0 / gnt1  output  1 each  one-cycle grant pulse to requester 0 / 1
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse; product written to RAM
- done_id  output  1  requester index of the job completing; valid while done=1
- rom_adr  output  3  ROM address to datapath
- rf_we, rf_da, rf_sa, rf_sb  output  1 each  register-file write enable, destination, read selects A and B
- ram_we  output  1  RAM write enable
- ram_adr  output  3  RAM address
- state  output  3  current FSM state encoding, for debug
- jobs_done  output  8  count of completed jobs

Function
REQ-003 The FSM SHALL have states IDLE=0, LOAD_A=1, LOAD_B=2, MULT=3, WRITE=4, DONE=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-004 IDLE SHALL go to LOAD_A when req0 or req1 is high at the edge, and otherwise stay in IDLE.
- LOAD_A -> LOAD_B -> MULT -> WRITE -> DONE -> IDLE, unconditionally, one cycle each.
REQ-005 On the IDLE->LOAD_A edge, the block SHALL latch the winner index and that requester's adr1, adr2 and dst; these latched values SHALL stay stable until the job ends.
REQ-006 Arbitration SHALL be round-robin with a last-served pointer, updated on the IDLE->LOAD_A edge. With both requests high, the requester not last served SHALL win; with one request high, that requester SHALL win.
REQ-007 After reset, the pointer SHALL equal 1, so requester 0 wins the first simultaneous request.
REQ-008 gnt0 or gnt1 (winner only) SHALL be high for exactly the LOAD_A cycle.
REQ-009 A request still high in the IDLE cycle after DONE SHALL be treated as a new job.
REQ-010 All datapath controls SHALL be Moore decodes of state and latched job; they SHALL be 0 in every state not listed below.
- LOAD_A: rom_adr=adr1, rf_we=1, rf_da=0
- LOAD_B: rom_adr=adr2, rf_we=1, rf_da=1
- MULT and WRITE: rf_sa=0, rf_sb=1
- WRITE: ram_we=1, ram_adr=dst
- DONE: ram_adr=dst
REQ-011 rom_adr and ram_adr SHALL be 0 in states where they are not driven.
REQ-012 done SHALL be high for exactly the DONE cycle, with done_id equal to the latched winner; done_id SHALL be 0 otherwise.
REQ-013 jobs_done SHALL increment by 1 on the WRITE->DONE edge and wrap from 255 to 0.
REQ-014 Latency from the request-sampling edge to done high SHALL be 5 cycles, with 6 cycles minimum per job.
REQ-015 Request or operand changes while busy SHALL be ignored.

Reset
REQ-016 While rst=0 at a rising edge, the block SHALL set the following:
- state=IDLE and pointer=1
- latched job (index, adr1, adr2, dst) = 0
- jobs_done=0
REQ-017 After that edge, all outputs SHALL be 0: gnt0, gnt1, busy, done, done_id, rom_adr, rf_we, rf_da, rf_sa, rf_sb, ram_we, ram_adr, state, jobs_done.
REQ-018 Reset asserted mid-job SHALL abort the job with no further ram_we and no done pulse; it SHALL take priority over every transition.
REQ-019 rst SHALL have no effect between clock edges.

Verification
REQ-020 Single job: req0=1, adr1_0=2, adr2_0=5, dst_0=3 -> the following, and jobs_done=1.
- gnt0 in cycle 1
- rom_adr=2 with rf_we=1, rf_da=0 in cycle 1
- rom_adr=5 with rf_da=1 in cycle 2
- ram_we=1, ram_adr=3 in cycle 4
- done=1, done_id=0 in cycle 5
REQ-021 Contention: req0=req1=1 held continuously after reset -> grants in order 0,1,0,1, six cycles apart, and done_id alternates 0,1,0,1.
REQ-022 Ignore-while-busy: req1 raised and adr1_0 changed during the MULT state of a req0 job -> that job's ROM/RAM addresses are unchanged, and gnt1 fires 6 cycles after gnt0.
REQ-023 Reset mid-op: rst=0 during LOAD_B -> next cycle state=0 and all outputs 0; no ram_we and no done ever occur for the aborted job.
REQ-024 Counter wrap: 256 completed jobs -> jobs_done reads 255 then 0, with the 256th done pulse present.
REQ-025 Illegal state: force state to 6 -> IDLE next edge, with all outputs 0.
